// File: rtl/controle_dispensa_pkg.sv
// Shared codes for the dispensing controller: FSM states, error codes, slot count
// and the row price helper.
package controle_dispensa_pkg;

    localparam logic [2:0] ESPERA   = 3'b000;
    localparam logic [2:0] VALIDA   = 3'b001;
    localparam logic [2:0] DISPENSA = 3'b010;
    localparam logic [2:0] CONCLUI  = 3'b011;
    localparam logic [2:0] ERRO     = 3'b100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ESTOQUE  = 2'b01;
    localparam logic [1:0] ERR_CREDITO  = 2'b10;
    localparam logic [1:0] ERR_MECANICA = 2'b11;

    localparam int NUM_SLOTS = 16;

    function automatic logic [7:0] calc_preco(input logic [1:0] lin, input int base, input int step);
        return 8'(base + int'(lin) * step);
    endfunction

endpackage

// File: rtl/controle_dispensa_temporizador.sv
// Loadable down-counter with a zero flag; shared by the motor timeout and the
// error hold interval.
module controle_dispensa_temporizador #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         carregar,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (carregar) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/controle_dispensa.sv
// Validates a keypad selection against stock and credit, runs the motor until the
// drop sensor fires, and reports change, error code and the OK release pulse.
module controle_dispensa
    import controle_dispensa_pkg::*;
#(
    parameter int PRICE_BASE    = 50,
    parameter int PRICE_STEP    = 25,
    parameter int STOCK_MAX     = 3,
    parameter int MOTOR_TIMEOUT = 100,
    parameter int ERRO_HOLD     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       selecao_pronta,
    input  logic [1:0] linha,
    input  logic [1:0] coluna,
    input  logic [7:0] credito,
    input  logic       sensor_queda,
    input  logic       reabastecer,
    output logic       OK,
    output logic       motor,
    output logic [1:0] motor_linha,
    output logic [1:0] motor_coluna,
    output logic [7:0] troco,
    output logic       troco_valido,
    output logic [1:0] erro,
    output logic [2:0] estadoMef2
);

    localparam int TMAX = (MOTOR_TIMEOUT > ERRO_HOLD) ? MOTOR_TIMEOUT : ERRO_HOLD;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]    estado;
    logic          selReg;
    logic          armado;
    logic [1:0]    linLat;
    logic [1:0]    colLat;
    logic [7:0]    credLat;
    logic [3:0]    estoque [NUM_SLOTS];
    logic [3:0]    slot;
    logic [7:0]    preco;
    logic          rejeita;
    logic          timerCarga;
    logic [TW-1:0] timerValor;
    logic          timerZero;

    assign slot    = {linLat, colLat};
    assign preco   = calc_preco(linLat, PRICE_BASE, PRICE_STEP);
    assign rejeita = (estoque[slot] == 4'd0) || (credLat < preco);

    // Timer is loaded minus one so its zero flag marks the last cycle of the interval.
    always_comb begin
        timerCarga = 1'b0;
        timerValor = '0;
        if (estado == VALIDA) begin
            timerCarga = 1'b1;
            timerValor = rejeita ? TW'(ERRO_HOLD - 1) : TW'(MOTOR_TIMEOUT - 1);
        end else if (estado == DISPENSA && !sensor_queda && timerZero) begin
            timerCarga = 1'b1;
            timerValor = TW'(ERRO_HOLD - 1);
        end
    end

    controle_dispensa_temporizador #(.W(TW)) uTemporizador (
        .clk      (clk),
        .rst_n    (rst_n),
        .carregar (timerCarga),
        .valor    (timerValor),
        .zero     (timerZero)
    );

    assign OK           = (estado == CONCLUI) || (estado == ERRO && timerZero);
    assign motor        = (estado == DISPENSA);
    assign motor_linha  = motor ? linLat : 2'b00;
    assign motor_coluna = motor ? colLat : 2'b00;
    assign estadoMef2   = estado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= ESPERA;
            selReg       <= 1'b0;
            armado       <= 1'b1;
            linLat       <= 2'b00;
            colLat       <= 2'b00;
            credLat      <= 8'd0;
            erro         <= ERR_NONE;
            troco        <= 8'd0;
            troco_valido <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) estoque[i] <= 4'(STOCK_MAX);
        end else begin
            selReg       <= selecao_pronta;
            troco_valido <= 1'b0;
            // A selection still held after OK must be released once before re-arming.
            if (OK) armado <= 1'b0;
            else if (!selReg) armado <= 1'b1;

            case (estado)
                ESPERA: begin
                    if (reabastecer) begin
                        for (int i = 0; i < NUM_SLOTS; i++) estoque[i] <= 4'(STOCK_MAX);
                    end else if (selReg && armado) begin
                        linLat  <= linha;
                        colLat  <= coluna;
                        credLat <= credito;
                        erro    <= ERR_NONE;
                        troco   <= 8'd0;
                        estado  <= VALIDA;
                    end
                end
                VALIDA: begin
                    if (rejeita) begin
                        erro         <= (estoque[slot] == 4'd0) ? ERR_ESTOQUE : ERR_CREDITO;
                        troco        <= credLat;
                        troco_valido <= 1'b1;
                        estado       <= ERRO;
                    end else begin
                        estado <= DISPENSA;
                    end
                end
                DISPENSA: begin
                    if (sensor_queda) begin
                        troco        <= credLat - preco;
                        troco_valido <= 1'b1;
                        estado       <= CONCLUI;
                    end else if (timerZero) begin
                        erro         <= ERR_MECANICA;
                        troco        <= credLat;
                        troco_valido <= 1'b1;
                        estado       <= ERRO;
                    end
                end
                CONCLUI: begin
                    estoque[slot] <= estoque[slot] - 4'd1;
                    estado        <= ESPERA;
                end
                ERRO: begin
                    if (timerZero) estado <= ESPERA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
